// File: rtl/edge_event_arbiter_pkg.sv
// Shared types for the edge event arbiter.
// Arbiter FSM states, edge-type bit positions, event bundle.
package edge_arb_pkg;

  typedef enum logic {
    IDLE,
    PRESENT
  } arb_state_e;

  localparam int RISE_BIT = 0;
  localparam int FALL_BIT = 1;
  localparam int MAX_CH_W = 4;

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic                rise;
    logic                fall;
  } evt_t;

endpackage

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any_req
);

  logic         w_found;
  int           w_idx;
  logic [W-1:0] w_sel;

  always_comb begin
    grant   = '0;
    any_req = |req;
    w_found = 1'b0;
    w_idx   = 0;
    w_sel   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(ptr) + i) % N;
      w_sel = W'(w_idx);
      if (!w_found && req[w_sel]) begin
        w_found = 1'b1;
        grant   = w_sel;
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge detector with round-robin event port.
// EDGE_ARB_TIMESTAMP_EN adds a per-event timestamp (evt_ts_o).
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
`ifdef EDGE_ARB_TIMESTAMP_EN
  parameter  int TS_W   = 16,
`endif
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   a_i,
  input  logic [2*NUM_CH-1:0] edge_type_i,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [CH_W-1:0]     evt_ch_o,
  output logic                evt_rise_o,
  output logic                evt_fall_o,
`ifdef EDGE_ARB_TIMESTAMP_EN
  output logic [TS_W-1:0]     evt_ts_o,
`endif
  input  logic                ovf_clr_i,
  output logic [NUM_CH-1:0]   ovf_o
);

  logic [NUM_CH-1:0] r_a_q;
  logic [NUM_CH-1:0] r_rise_pend;
  logic [NUM_CH-1:0] r_fall_pend;
  logic [NUM_CH-1:0] r_ovf;
  logic              r_init;
  logic [CH_W-1:0]   r_rr_ptr;
  evt_t              r_evt;
  arb_state_e        r_state;
  arb_state_e        w_state_d;

  logic [NUM_CH-1:0] w_rise_en;
  logic [NUM_CH-1:0] w_fall_en;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_gmask;
  logic [NUM_CH-1:0] w_ovf;
  logic [CH_W-1:0]   w_grant;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic              w_any;
  logic              w_load;

  always_comb begin
    w_rise_en = '0;
    w_fall_en = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_rise_en[k] = edge_type_i[2*k+RISE_BIT];
      w_fall_en[k] = edge_type_i[2*k+FALL_BIT];
    end
  end

  // No edges on the first clock after reset: a_q is not yet valid.
  assign w_rise = a_i & ~r_a_q & w_rise_en
                & {NUM_CH{~r_init}};
  assign w_fall = ~a_i & r_a_q & w_fall_en
                & {NUM_CH{~r_init}};
  assign w_pend = r_rise_pend | r_fall_pend;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_rr (
    .req     (w_pend),
    .ptr     (r_rr_ptr),
    .grant   (w_grant),
    .any_req (w_any)
  );

  assign w_gmask = w_load
                 ? (NUM_CH'(1) << w_grant)
                 : '0;
  assign w_ovf = ((w_rise & r_rise_pend)
               | (w_fall & r_fall_pend))
               & ~w_gmask;
  assign w_ptr_nxt =
    (w_grant == CH_W'(NUM_CH-1))
    ? '0 : w_grant + 1'b1;

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load    = 1'b1;
          w_state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready_i) begin
          w_load    = w_any;
          w_state_d = w_any ? PRESENT : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  // New edges OR in after the grant clear, so set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_init      <= 1'b1;
      r_a_q       <= '0;
      r_rise_pend <= '0;
      r_fall_pend <= '0;
      r_ovf       <= '0;
      r_rr_ptr    <= '0;
      r_evt       <= '0;
    end else begin
      r_init      <= 1'b0;
      r_a_q       <= a_i;
      r_rise_pend <= (r_rise_pend & ~w_gmask) | w_rise;
      r_fall_pend <= (r_fall_pend & ~w_gmask) | w_fall;
      r_ovf       <= (ovf_clr_i ? '0 : r_ovf) | w_ovf;
      if (w_load) begin
        r_evt.ch   <= MAX_CH_W'(w_grant);
        r_evt.rise <= r_rise_pend[w_grant];
        r_evt.fall <= r_fall_pend[w_grant];
        r_rr_ptr   <= w_ptr_nxt;
      end
    end
  end

  assign evt_valid_o = (r_state == PRESENT);
  assign evt_ch_o    = CH_W'(r_evt.ch);
  assign evt_rise_o  = r_evt.rise;
  assign evt_fall_o  = r_evt.fall;
  assign ovf_o       = r_ovf;

`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0]   r_ts_cnt;
  logic [TS_W-1:0]   r_evt_ts;
  logic [TS_W-1:0]   r_ts_q [NUM_CH];
  logic [NUM_CH-1:0] w_ts_cap;

  // Stamp only on the not-pending -> pending transition.
  assign w_ts_cap = (w_rise | w_fall)
                  & ~(w_pend & ~w_gmask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts_cnt <= '0;
      r_evt_ts <= '0;
      for (int k = 0; k < NUM_CH; k++)
        r_ts_q[k] <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
      for (int k = 0; k < NUM_CH; k++)
        if (w_ts_cap[k]) r_ts_q[k] <= r_ts_cnt;
      if (w_load) r_evt_ts <= r_ts_q[w_grant];
    end
  end

  assign evt_ts_o = r_evt_ts;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed scoreboard bench for edge_event_arbiter.
// Expected events are queued at stimulus and popped on handshake.
module tb_edge_event_arbiter;

  typedef struct packed {
    logic [1:0] ch;
    logic       rise;
    logic       fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a_i;
  logic [7:0] edge_type_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [1:0] evt_ch_o;
  logic       evt_rise_o;
  logic       evt_fall_o;
  logic       ovf_clr_i;
  logic [3:0] ovf_o;
`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [15:0] evt_ts_o;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  edge_event_arbiter #(
    .NUM_CH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a_i         (a_i),
    .edge_type_i (edge_type_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_ch_o    (evt_ch_o),
    .evt_rise_o  (evt_rise_o),
    .evt_fall_o  (evt_fall_o),
`ifdef EDGE_ARB_TIMESTAMP_EN
    .evt_ts_o    (evt_ts_o),
`endif
    .ovf_clr_i   (ovf_clr_i),
    .ovf_o       (ovf_o)
  );

  function automatic exp_t mk(input int c,
                              input bit r,
                              input bit f);
    exp_t e;
    e.ch   = 2'(c);
    e.rise = r;
    e.fall = f;
    return e;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    check("drain", q.size(), 0);
    q.delete();
    repeat (3) tick();
    @(negedge clk);
    check("drain_idle", evt_valid_o, 0);
    tick();
  endtask

  // A valid&ready seen here completes at the next posedge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && evt_valid_o && evt_ready_i) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_evt: got ch=%0d r=%0b f=%0b want none",
               evt_ch_o, evt_rise_o, evt_fall_o);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        check("evt", {evt_ch_o, evt_rise_o,
                      evt_fall_o}, e);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    a_i         = 4'b0010;
    edge_type_i = 8'hFF;
    evt_ready_i = 1'b0;
    ovf_clr_i   = 1'b0;
    #2 reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", evt_valid_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_ch", evt_ch_o, 0);
    check("rst_rise", evt_rise_o, 0);
    check("rst_fall", evt_fall_o, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held_high", evt_valid_o, 0);
      tick();
    end

    // single rise, latency
    evt_ready_i = 1'b1;
    q.push_back(mk(0, 1, 0));
    a_i = 4'b0011;
    @(negedge clk);
    check("lat_drive", evt_valid_o, 0);
    tick();
    @(negedge clk);
    check("lat_pend", evt_valid_o, 0);
    tick();
    @(negedge clk);
    check("lat_valid", evt_valid_o, 1);
    tick();
    @(negedge clk);
    check("lat_done", evt_valid_o, 0);
    tick();
    drain();

    // wrap: ptr=1 so ch1 before ch0
    q.push_back(mk(1, 0, 1));
    q.push_back(mk(0, 0, 1));
    a_i = 4'b0000;
    drain();

    // ch1 and ch3 back-to-back
    q.push_back(mk(1, 1, 0));
    q.push_back(mk(3, 1, 0));
    a_i = 4'b1010;
    tick();
    tick();
    @(negedge clk);
    check("b2b_v1", evt_valid_o, 1);
    check("b2b_ch1", evt_ch_o, 1);
    tick();
    @(negedge clk);
    check("b2b_v2", evt_valid_o, 1);
    check("b2b_ch2", evt_ch_o, 3);
    tick();
    @(negedge clk);
    check("b2b_end", evt_valid_o, 0);
    tick();
    drain();

    // ptr back at 0: ch0 wins over ch3
    q.push_back(mk(0, 1, 0));
    q.push_back(mk(3, 0, 1));
    a_i = 4'b0011;
    drain();

    // ch2 falling disabled
    edge_type_i = 8'hDF;
    q.push_back(mk(2, 1, 0));
    a_i = 4'b0111;
    tick();
    a_i = 4'b0011;
    drain();
    edge_type_i = 8'hFF;

    q.push_back(mk(0, 0, 1));
    a_i = 4'b0010;
    drain();

    // stalled: ch0 rise, fall, rise -> merged + overflow
    evt_ready_i = 1'b0;
    q.push_back(mk(3, 1, 0));
    q.push_back(mk(0, 1, 1));
    a_i = 4'b1010;
    tick();
    tick();
    @(negedge clk);
    check("stall_valid", evt_valid_o, 1);
    check("stall_ch", evt_ch_o, 3);
    tick();
    a_i = 4'b1011;
    tick();
    a_i = 4'b1010;
    @(negedge clk);
    check("ovf_none", ovf_o, 0);
    tick();
    a_i = 4'b1011;
    tick();
    @(negedge clk);
    check("ovf_set", ovf_o, 4'b0001);
    check("stall_hold", evt_ch_o, 3);
    tick();
    evt_ready_i = 1'b1;
    drain();
    @(negedge clk);
    check("ovf_sticky", ovf_o, 4'b0001);
    tick();
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    @(negedge clk);
    check("ovf_clr", ovf_o, 0);
    tick();

    // reset mid-handshake discards everything
    evt_ready_i = 1'b0;
    a_i = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    check("pre_rst_valid", evt_valid_o, 1);
    check("pre_rst_ch", evt_ch_o, 2);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", evt_valid_o, 0);
    check("mid_rst_ch", evt_ch_o, 0);
    check("mid_rst_rise", evt_rise_o, 0);
    tick();
    evt_ready_i = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst", evt_valid_o, 0);
      tick();
    end

`ifdef EDGE_ARB_TIMESTAMP_EN
    reset = 1'b0;
    a_i = 4'b0000;
    evt_ready_i = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    repeat (7) tick();
    q.push_back(mk(1, 1, 0));
    a_i = 4'b0010;
    repeat (2) tick();
    repeat (5) tick();
    @(negedge clk);
    check("ts_valid", evt_valid_o, 1);
    check("ts_value", evt_ts_o, 16'h0007);
    tick();
    evt_ready_i = 1'b1;
    drain();
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
